// File: rtl/approx_mul_rr_sched.sv
// Round-robin scheduler that time-shares one external combinational approximate
// multiplier among NREQ requesters through a registered issue stage and a registered result stage.
module approx_mul_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_x,
    input  logic [NREQ*W-1:0]    req_y,
    output logic [W-1:0]         mul_x,
    output logic [W-1:0]         mul_y,
    input  logic [2*W-1:0]       mul_z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*W-1:0]       rsp_z,
    output logic                 busy,
    output logic [15:0]          op_count
);

    logic            iv_q, iv_d;
    logic [W-1:0]    iss_x_q, iss_x_d;
    logic [W-1:0]    iss_y_q, iss_y_d;
    logic [IDW-1:0]  iss_id_q, iss_id_d;
    logic            rv_q, rv_d;
    logic [2*W-1:0]  res_z_q, res_z_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [15:0]     op_cnt_q, op_cnt_d;

    logic            res_free, iss_adv, iss_free, accept;
    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  cand;
    logic [IDW:0]    sum;
    logic [W-1:0]    win_x, win_y;

    // Search starts at ptr and wraps at NREQ, which need not be a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        sum       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                cand = IDW'(sum - (IDW+1)'(NREQ));
            end else begin
                cand = IDW'(sum);
            end
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_x = '0;
        win_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_idx) begin
                win_x = req_x[i*W +: W];
                win_y = req_y[i*W +: W];
            end
        end
    end

    always_comb begin
        res_free  = !rv_q || rsp_ready;
        iss_adv   = iv_q && res_free;
        iss_free  = !iv_q || iss_adv;
        accept    = win_found && iss_free;
        req_ready = '0;
        if (!rst && win_found) begin
            req_ready[win_idx] = iss_free;
        end
    end

    always_comb begin
        iv_d     = iv_q;
        iss_x_d  = iss_x_q;
        iss_y_d  = iss_y_q;
        iss_id_d = iss_id_q;
        ptr_d    = ptr_q;
        rv_d     = rv_q;
        res_z_d  = res_z_q;
        res_id_d = res_id_q;
        op_cnt_d = op_cnt_q;
        if (accept) begin
            iv_d     = 1'b1;
            iss_x_d  = win_x;
            iss_y_d  = win_y;
            iss_id_d = win_idx;
            ptr_d    = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
        end else if (iss_adv) begin
            iv_d = 1'b0;
        end
        if (iss_adv) begin
            rv_d     = 1'b1;
            res_z_d  = mul_z;
            res_id_d = iss_id_q;
        end else if (rsp_ready) begin
            rv_d = 1'b0;
        end
        if (rv_q && rsp_ready && op_cnt_q != 16'hFFFF) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iv_q     <= 1'b0;
            iss_x_q  <= '0;
            iss_y_q  <= '0;
            iss_id_q <= '0;
            rv_q     <= 1'b0;
            res_z_q  <= '0;
            res_id_q <= '0;
            ptr_q    <= '0;
            op_cnt_q <= '0;
        end else begin
            iv_q     <= iv_d;
            iss_x_q  <= iss_x_d;
            iss_y_q  <= iss_y_d;
            iss_id_q <= iss_id_d;
            rv_q     <= rv_d;
            res_z_q  <= res_z_d;
            res_id_q <= res_id_d;
            ptr_q    <= ptr_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    // Operands are gated to zero while idle so the shared multiplier does not toggle.
    assign mul_x     = iv_q ? iss_x_q : '0;
    assign mul_y     = iv_q ? iss_y_q : '0;
    assign rsp_valid = rv_q;
    assign rsp_z     = res_z_q;
    assign rsp_id    = res_id_q;
    assign busy      = iv_q || rv_q;
    assign op_count  = op_cnt_q;

endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// Self-checking bench for approx_mul_rr_sched: directed scenarios plus a randomized run
// checked against a transaction-level model (in-order queue, capacity two, one-cycle issue).
module tb_approx_mul_rr_sched;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_x = '0;
    logic [NREQ*W-1:0]   req_y = '0;
    logic [W-1:0]        mul_x, mul_y;
    logic [2*W-1:0]      mul_z;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [2*W-1:0]      rsp_z;
    logic                busy;
    logic [15:0]         op_count;
    logic                mul_mode = 1'b0;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int          id;
        logic [15:0] z;
        logic [7:0]  x;
        logic [7:0]  y;
        int          acc;
    } txn_t;

    approx_mul_rr_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_z(rsp_z),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Approximate multiplier: exact upper byte, OR-compressed partial products in the lower byte.
    function automatic logic [15:0] approx_f(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ex;
        logic [7:0]  lo;
        ex = 16'(a) * 16'(b);
        lo = '0;
        for (int i = 0; i < 8; i++) if (a[i]) lo = lo | 8'(b << i);
        return {ex[15:8], lo};
    endfunction

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        return mul_mode ? approx_f(a, b) : 16'(a) * 16'(b);
    endfunction

    assign mul_z = ref_mul(mul_x, mul_y);

    task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        mul_mode = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd7);
        step();
        @(negedge clk);
        cmp_cnt++;
        if ({req_ready, rsp_valid, rsp_id, rsp_z, mul_x, mul_y, busy, op_count} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs rdy=%b rv=%b id=%0d z=%h mx=%h my=%h busy=%b cnt=%0d exp all zero",
                     req_ready, rsp_valid, rsp_id, rsp_z, mul_x, mul_y, busy, op_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (req_ready !== 4'b0001) begin
            err_cnt++;
            $display("FAIL reset_ptr0 got=%b exp=0001", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_single();
        apply_reset();
        set_req(2, 8'd3, 8'd5);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if (req_ready !== 4'b0100) begin
            err_cnt++;
            $display("FAIL single_ready got=%b exp=0100", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        cmp_cnt++;
        if ({rsp_valid, mul_x, mul_y} !== {1'b0, 8'd3, 8'd5}) begin
            err_cnt++;
            $display("FAIL single_issue got rv=%b mx=%0d my=%0d exp rv=0 mx=3 my=5", rsp_valid, mul_x, mul_y);
        end
        step();
        @(negedge clk);
        cmp_cnt++;
        if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'd2, 16'd15}) begin
            err_cnt++;
            $display("FAIL single_rsp got rv=%b id=%0d z=%0d exp rv=1 id=2 z=15", rsp_valid, rsp_id, rsp_z);
        end
        step();
        @(negedge clk);
        cmp_cnt++;
        if ({busy, rsp_valid, op_count} !== {1'b0, 1'b0, 16'd1}) begin
            err_cnt++;
            $display("FAIL single_done got busy=%b rv=%b cnt=%0d exp busy=0 rv=0 cnt=1", busy, rsp_valid, op_count);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd10);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (cyc < 5) begin
                cmp_cnt++;
                if (req_ready !== 4'(1 << order[cyc])) begin
                    err_cnt++;
                    $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, req_ready, 4'(1 << order[cyc]));
                end
            end
            if (cyc >= 2) begin
                cmp_cnt++;
                if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'(cyc - 2), 16'((cyc - 1) * 10)}) begin
                    err_cnt++;
                    $display("FAIL rr_rsp cyc=%0d got rv=%b id=%0d z=%0d exp rv=1 id=%0d z=%0d",
                             cyc, rsp_valid, rsp_id, rsp_z, cyc - 2, (cyc - 1) * 10);
                end
            end
            if (cyc == 5) req_valid = '0;
            step();
        end
        repeat (3) step();
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_rdy[5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        apply_reset();
        set_req(0, 8'd7, 8'd9);
        set_req(1, 8'd11, 8'd13);
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            cmp_cnt++;
            if (req_ready !== exp_rdy[cyc]) begin
                err_cnt++;
                $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy[cyc]);
            end
            if (cyc >= 2) begin
                cmp_cnt++;
                if ({rsp_valid, rsp_id, rsp_z, mul_x, mul_y} !== {1'b1, 2'd0, 16'd63, 8'd11, 8'd13}) begin
                    err_cnt++;
                    $display("FAIL bp_stall cyc=%0d got rv=%b id=%0d z=%0d mx=%0d my=%0d exp 1/0/63/11/13",
                             cyc, rsp_valid, rsp_id, rsp_z, mul_x, mul_y);
                end
            end
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        cmp_cnt++;
        if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'd0, 16'd63}) begin
            err_cnt++;
            $display("FAIL bp_drain0 got rv=%b id=%0d z=%0d exp 1/0/63", rsp_valid, rsp_id, rsp_z);
        end
        step();
        @(negedge clk);
        cmp_cnt++;
        if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'd1, 16'd143}) begin
            err_cnt++;
            $display("FAIL bp_drain1 got rv=%b id=%0d z=%0d exp 1/1/143", rsp_valid, rsp_id, rsp_z);
        end
        step();
        @(negedge clk);
        cmp_cnt++;
        if ({rsp_valid, busy, op_count} !== {1'b0, 1'b0, 16'd2}) begin
            err_cnt++;
            $display("FAIL bp_done got rv=%b busy=%b cnt=%0d exp 0/0/2", rsp_valid, busy, op_count);
        end
    endtask

    task automatic test_approx();
        apply_reset();
        mul_mode = 1'b1;
        rsp_ready = 1'b1;
        set_req(1, 8'hF0, 8'hFF);
        req_valid = 4'b0010;
        @(negedge clk);
        cmp_cnt++;
        if (req_ready !== 4'b0010) begin
            err_cnt++;
            $display("FAIL approx_ready got=%b exp=0010", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        cmp_cnt++;
        if ({mul_x, mul_y} !== {8'hF0, 8'hFF}) begin
            err_cnt++;
            $display("FAIL approx_issue got mx=%h my=%h exp F0/FF", mul_x, mul_y);
        end
        step();
        @(negedge clk);
        cmp_cnt++;
        if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'd1, 16'hEFF0}) begin
            err_cnt++;
            $display("FAIL approx_rsp got rv=%b id=%0d z=%h exp 1/1/EFF0", rsp_valid, rsp_id, rsp_z);
        end
        step();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rsp_ready = 1'b0;
        set_req(0, 8'h21, 8'h02);
        set_req(1, 8'h13, 8'h04);
        set_req(3, 8'h55, 8'h66);
        req_valid = 4'b0011;
        step();
        step();
        @(negedge clk);
        cmp_cnt++;
        if ({busy, rsp_valid, req_ready} !== {1'b1, 1'b1, 4'b0000}) begin
            err_cnt++;
            $display("FAIL rstmid_full got busy=%b rv=%b rdy=%b exp 1/1/0000", busy, rsp_valid, req_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        cmp_cnt++;
        if ({req_ready, rsp_valid, rsp_id, rsp_z, mul_x, mul_y, busy, op_count} !== '0) begin
            err_cnt++;
            $display("FAIL rstmid_async rdy=%b rv=%b id=%0d z=%h mx=%h my=%h busy=%b cnt=%0d exp all zero",
                     req_ready, rsp_valid, rsp_id, rsp_z, mul_x, mul_y, busy, op_count);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            cmp_cnt++;
            if ({rsp_valid, busy} !== 2'b00) begin
                err_cnt++;
                $display("FAIL rstmid_ghost cyc=%0d got rv=%b busy=%b exp 0/0", cyc, rsp_valid, busy);
            end
            step();
        end
        req_valid = 4'b1001;
        @(negedge clk);
        cmp_cnt++;
        if (req_ready !== 4'b0001) begin
            err_cnt++;
            $display("FAIL rstmid_ptr got=%b exp=0001", req_ready);
        end
        step();
        req_valid = '0;
        repeat (3) step();
    endtask

    task automatic test_random();
        txn_t       q[$];
        txn_t       t;
        int         ptr_m, edge_n, cnt_m, win, c;
        bit         presented, can, has_iss;
        logic [3:0] just_acc, exp_rdy;
        logic [7:0] ix, iy;
        apply_reset();
        mul_mode = 1'($urandom_range(0, 1));
        ptr_m = 0; edge_n = 0; cnt_m = 0; just_acc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || just_acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            presented = (q.size() > 0) && (edge_n >= q[0].acc + 1);
            win = -1;
            for (int k = 0; k < NREQ; k++) begin
                c = (ptr_m + k) % NREQ;
                if (win < 0 && req_valid[c]) win = c;
            end
            can = (q.size() < 2) || rsp_ready;
            exp_rdy = (win >= 0 && can) ? 4'(1 << win) : 4'b0000;
            has_iss = 1'b0; ix = '0; iy = '0;
            if (q.size() == 2) begin
                has_iss = 1'b1; ix = q[1].x; iy = q[1].y;
            end else if (q.size() == 1 && !presented) begin
                has_iss = 1'b1; ix = q[0].x; iy = q[0].y;
            end
            cmp_cnt++;
            if (req_ready !== exp_rdy) begin
                err_cnt++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
            end
            cmp_cnt++;
            if ({rsp_valid, busy, op_count} !== {presented, q.size() > 0, 16'(cnt_m)}) begin
                err_cnt++;
                $display("FAIL rand_status cyc=%0d got rv=%b busy=%b cnt=%0d exp rv=%b busy=%b cnt=%0d",
                         cyc, rsp_valid, busy, op_count, presented, q.size() > 0, cnt_m);
            end
            cmp_cnt++;
            if ({mul_x, mul_y} !== {ix, iy}) begin
                err_cnt++;
                $display("FAIL rand_mul cyc=%0d got mx=%h my=%h exp mx=%h my=%h iss=%b",
                         cyc, mul_x, mul_y, ix, iy, has_iss);
            end
            if (presented) begin
                cmp_cnt++;
                if ({rsp_id, rsp_z} !== {2'(q[0].id), q[0].z}) begin
                    err_cnt++;
                    $display("FAIL rand_rsp cyc=%0d got id=%0d z=%h exp id=%0d z=%h",
                             cyc, rsp_id, rsp_z, q[0].id, q[0].z);
                end
            end
            just_acc = '0;
            if (presented && rsp_ready) begin
                void'(q.pop_front());
                if (cnt_m < 65535) cnt_m++;
            end
            if (win >= 0 && can) begin
                t.id = win;
                t.x = req_x[win*W +: W];
                t.y = req_y[win*W +: W];
                t.z = ref_mul(t.x, t.y);
                t.acc = edge_n + 1;
                q.push_back(t);
                ptr_m = (win + 1) % NREQ;
                just_acc[win] = 1'b1;
            end
            step();
            edge_n++;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd3);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int n = 0; n <= 65540; n++) begin
            @(posedge clk);
            if (n == 65535 || n == 65536 || n == 65540) begin
                @(negedge clk);
                cmp_cnt++;
                if (op_count !== ((n == 65535) ? 16'hFFFE : 16'hFFFF)) begin
                    err_cnt++;
                    $display("FAIL sat_count edge=%0d got=%h exp=%h", n, op_count,
                             (n == 65535) ? 16'hFFFE : 16'hFFFF);
                end
            end
        end
        #1;
        req_valid = '0;
        repeat (3) step();
    endtask

    initial begin
        #2_000_000;
        err_cnt++;
        $display("FAIL watchdog time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_approx();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/approx_mul_rr_sched.md
Name: approx_mul_rr_sched

Overview:
- Time-shares one combinational 8x8 unsigned approximate multiplier (x, y -> z) among NREQ requesters.
- Round-robin arbitration, registered operand issue, registered result return with requester ID.
- Valid/ready handshakes on both sides; sits between accelerator lanes and a single multiplier instance, so multiplier area is paid once.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; product width is 2*W.
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_x  in  NREQ*W  packed operands x; requester i uses bits [i*W +: W].
- req_y  in  NREQ*W  packed operands y, same packing.
- mul_x  out  W  operand x to the shared multiplier.
- mul_y  out  W  operand y to the shared multiplier.
- mul_z  in  2*W  product from the shared multiplier (combinational from mul_x/mul_y).
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  IDW  requester index of the result.
- rsp_z  out  2*W  product.
- busy  out  1  high when any pipeline stage holds a valid entry.
- op_count  out  16  completed responses, saturating.

Behaviour:
- Two registered stages:
  - Issue: iv, iss_x, iss_y, iss_id.
  - Result: rv, res_z, res_id.
- mul_x = iv ? iss_x : 0 and mul_y = iv ? iss_y : 0. Operands are gated to cut toggling.
- Result stage capture: res_z <= mul_z and res_id <= iss_id when the issue stage advances.
- Advance rules:
  - res_free = !rv | rsp_ready.
  - iss_adv = iv & res_free.
  - iss_free = !iv | iss_adv.
- Arbitration:
  - Round-robin pointer ptr (IDW bits).
  - Search order: ptr, ptr+1, ..., wrapping modulo NREQ.
  - The first i with req_valid[i] is the winner.
  - req_ready[winner] = iss_free; all other req_ready bits are 0.
  - req_ready is combinational from req_valid, ptr and stage state.
- On an accept (req_valid[i] & req_ready[i]):
  - iss_x/iss_y/iss_id <= requester i's operands and i.
  - iv <= 1.
  - ptr <= (i+1) mod NREQ.
  - No accept: iv <= 0 if iss_adv, else iv holds. ptr holds.
- Result stage: rv <= 1 on iss_adv. rv <= 0 when rsp_ready and no iss_adv. Otherwise rv holds.
- Outputs: rsp_valid = rv, rsp_z = res_z, rsp_id = res_id.
- Latency: accept at edge t -> rsp_valid high in the cycle after edge t+1, i.e. 2 cycles.
- Throughput: 1 result/cycle while rsp_ready stays high.
- Backpressure:
  - rv & !rsp_ready stalls the result stage, and the issue stage holds if iv.
  - With both stages full, req_ready is all zero.
  - Stalled registers and mul_x/mul_y stay stable.
- Requester hold rule: a requester keeps valid and operands stable until accepted. The block does not store unaccepted requests.
- op_count increments on each rsp_valid & rsp_ready and saturates at 0xFFFF.
- busy = iv | rv.
- Reset (asynchronous, any time including mid-operation):
  - iv, rv, ptr, iss_*, res_*, op_count all 0.
  - In-flight operations are dropped without a response.
  - Outputs: req_ready 0, rsp_valid 0, rsp_z 0, rsp_id 0, mul_x 0, mul_y 0, busy 0, op_count 0.
- Out-of-range ptr cannot occur. If NREQ is not a power of two, ptr wraps from NREQ-1 to 0.
- No combinational path from mul_z to any output except through res_z.

Test Plan:
- Single request, bench mul_z = exact product stub: req 2 presents x=3, y=5, rsp_ready=1.
  - Accepted at the first edge.
  - rsp_valid=1, rsp_id=2, rsp_z=15 two cycles later.
  - busy then falls; op_count=1.
- Round-robin fairness, exact stub: all four requesters valid continuously with x=i+1, y=10 (ptr=0 after reset).
  - Accept order is 0,1,2,3,0.
  - Responses (id,z) are (0,10),(1,20),(2,30),(3,40), one per cycle.
- Backpressure: rsp_ready=0 for 5 cycles with requesters 0 and 1 valid.
  - Exactly two accepts, then req_ready=0.
  - rsp_z and mul_x/mul_y stay stable.
  - On rsp_ready=1, both responses drain in order with no loss or duplication.
- Real approximate multiplier attached: x=8'hF0, y=8'hFF.
  - rsp_z equals that multiplier's output for the same operands (16'hEFF0), latched with no corruption.
- Reset mid-operation: assert rst asynchronously with both stages full.
  - All outputs go to 0 immediately and no response appears after release.
  - The first request after release is granted starting from ptr=0.
- Saturation: preload op_count near saturation by forcing, or run 65536+ transactions.
  - op_count stops at 0xFFFF and does not wrap.
